// File: rtl/seg_pkg.sv
// Shared encodings for the seven-segment scan driver: segment patterns, hex decode, FSM states.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: unsigned binary to BCD_DIGITS packed BCD digits, sticky overflow.
// Latency: DATA_W cycles after start_vld; done_vld is high during the last shift.
// No backpressure: start_vld restarts the conversion immediately, even mid-flight.
module bin2bcd_seq #(
    parameter int DATA_W     = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_vld,
    input  logic [DATA_W-1:0]       bin_dat,
    output logic                    done_vld,
    output logic [BCD_DIGITS*4-1:0] bcd_dat,
    output logic                    ovf_pend
);

    localparam int N  = BCD_DIGITS * 4;
    localparam int CW = $clog2(DATA_W) + 1;

    logic          active;
    logic [CW-1:0] shift_cnt;
    logic [DATA_W-1:0] bin_q;
    logic [N-1:0]  bcd_q;
    logic [N-1:0]  bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign done_vld = active && (shift_cnt == CW'(DATA_W - 1));
    assign bcd_dat  = bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            shift_cnt <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_pend  <= 1'b0;
        end else if (start_vld) begin
            active    <= 1'b1;
            shift_cnt <= '0;
            bin_q     <= bin_dat;
            bcd_q     <= '0;
            ovf_pend  <= 1'b0;
        end else if (active) begin
            // a carry out of the top digit means the value needs one more decimal digit
            {bcd_q, bin_q} <= {bcd_adj[N-2:0], bin_q, 1'b0};
            ovf_pend       <= ovf_pend | bcd_adj[N-1];
            shift_cnt      <= shift_cnt + CW'(1);
            if (done_vld) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_signed.sv
// Multiplexed common-anode 7-seg driver for a signed value: sign-magnitude decimal, blanking, overflow.
// Latency: sample to display commit DATA_W+2 cycles, conversions restart back to back.
// No backpressure: data is sampled once per conversion; SEG_SCAN_HEX_MODE_EN adds a raw hex_mode input.
module seg_scan_signed
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_MAX = 65000,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
`ifdef SEG_SCAN_HEX_MODE_EN
    input  logic              hex_mode,
`endif
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp,
    output logic              busy,
    output logic              ovf
);

    localparam int BCD_DIGITS = DIGITS - 1;
    localparam int IDX_W      = $clog2(DIGITS);

    state_t state_q, state_nxt;
    logic   sign_q;
    logic   start_vld, done_vld, commit;
    logic   [DATA_W-1:0] mag;
    logic   [BCD_DIGITS*4-1:0] bcd_dat;
    logic   ovf_pend;
    logic   [DIGITS-1:0][6:0] disp_q, disp_nxt;
    logic   ovf_nxt;
    logic   upper_zero;
    logic   [CNT_W-1:0] cnt_q;
    logic   [IDX_W-1:0] idx_q, idx_nxt;
    logic   cnt_wrap;

`ifdef SEG_SCAN_HEX_MODE_EN
    localparam int HEX_W = (DATA_W > 4*DIGITS) ? DATA_W : 4*DIGITS;
    logic             hex_q;
    logic [HEX_W-1:0] raw_q;
`endif

    // unsigned result keeps -2^(DATA_W-1) exact
    assign mag  = data[DATA_W-1] ? (~data + DATA_W'(1)) : data;
    assign dp   = 1'b1;
    assign busy = (state_q != IDLE);

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_vld (start_vld),
        .bin_dat   (mag),
        .done_vld  (done_vld),
        .bcd_dat   (bcd_dat),
        .ovf_pend  (ovf_pend)
    );

    always_comb begin
        state_nxt = state_q;
        start_vld = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                start_vld = 1'b1;
                state_nxt = SHIFT;
`ifdef SEG_SCAN_HEX_MODE_EN
                if (hex_mode) begin
                    start_vld = 1'b0;
                    state_nxt = DONE;
                end
`endif
            end
            SHIFT: begin
                if (done_vld) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        upper_zero = 1'b1;
        disp_nxt   = {DIGITS{SEG_BLANK}};
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            upper_zero  = upper_zero && (bcd_dat[i*4 +: 4] == 4'd0);
            disp_nxt[i] = (i != 0 && upper_zero) ? SEG_BLANK : seg_decode(bcd_dat[i*4 +: 4]);
        end
        disp_nxt[DIGITS-1] = (sign_q && !upper_zero) ? SEG_MINUS : SEG_BLANK;
        ovf_nxt = ovf_pend;
`ifdef SEG_SCAN_HEX_MODE_EN
        if (hex_q) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp_nxt[i] = seg_decode(raw_q[i*4 +: 4]);
            end
            ovf_nxt = |(raw_q >> (4*DIGITS));
        end
`endif
        if (ovf_nxt) begin
            disp_nxt = {DIGITS{SEG_MINUS}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            disp_q  <= {DIGITS{SEG_BLANK}};
            ovf     <= 1'b0;
`ifdef SEG_SCAN_HEX_MODE_EN
            hex_q   <= 1'b0;
            raw_q   <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            if (state_q == IDLE) begin
                sign_q <= data[DATA_W-1];
`ifdef SEG_SCAN_HEX_MODE_EN
                hex_q  <= hex_mode;
                raw_q  <= HEX_W'(data);
`endif
            end
            if (commit) begin
                disp_q <= disp_nxt;
                ovf    <= ovf_nxt;
            end
        end
    end

    assign cnt_wrap = (cnt_q == CNT_W'(CNT_MAX));

    always_comb begin
        idx_nxt = idx_q;
        if (cnt_wrap) begin
            idx_nxt = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // an and seg follow the same next index, so the anode never shows a stale pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg   <= SEG_BLANK;
            an    <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            cnt_q <= cnt_wrap ? '0 : cnt_q + CNT_W'(1);
            idx_q <= idx_nxt;
            an    <= ~(DIGITS'(1) << idx_nxt);
            seg   <= disp_q[idx_nxt];
        end
    end

endmodule

// File: tb/tb_seg_scan_signed.sv
// Scoreboard bench: stimulus pushes hand-computed digit patterns, a monitor checks a full scan of them.
module tb_seg_scan_signed;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0]  d8;
    logic [11:0] d12;
    logic [6:0]  seg8, seg12;
    logic [3:0]  an8, an12;
    logic        dp8, dp12, busy8, busy12, ovf8, ovf12;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic            which;
        logic [3:0][6:0] dig;
        logic            ovf;
        logic [7:0]      id;
    } exp_t;

    exp_t sb[$];
    logic mon_active = 1'b0;

    always #5 clk = ~clk;

    seg_scan_signed #(.DIGITS(4), .DATA_W(8), .CNT_MAX(3), .CNT_W(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (d8),
`ifdef SEG_SCAN_HEX_MODE_EN
        .hex_mode (1'b0),
`endif
        .seg   (seg8),
        .an    (an8),
        .dp    (dp8),
        .busy  (busy8),
        .ovf   (ovf8)
    );

    seg_scan_signed #(.DIGITS(4), .DATA_W(12), .CNT_MAX(3), .CNT_W(2)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (d12),
`ifdef SEG_SCAN_HEX_MODE_EN
        .hex_mode (1'b0),
`endif
        .seg   (seg12),
        .an    (an12),
        .dp    (dp12),
        .busy  (busy12),
        .ovf   (ovf12)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_falls(input logic which, input int n);
        int   seen = 0;
        int   budget = 0;
        logic prev, cur;
        prev = which ? busy12 : busy8;
        while (seen < n && budget < 200) begin
            @(negedge clk);
            budget++;
            cur = which ? busy12 : busy8;
            if (prev && !cur) seen++;
            prev = cur;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL busy_fall_timeout: got %0d falls, required %0d", seen, n);
        end
    endtask

    task automatic wait_rise(input logic which);
        int   budget = 0;
        logic prev, cur;
        logic hit = 1'b0;
        prev = which ? busy12 : busy8;
        while (!hit && budget < 200) begin
            @(negedge clk);
            budget++;
            cur = which ? busy12 : busy8;
            if (!prev && cur) hit = 1'b1;
            prev = cur;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL busy_rise_timeout: got no rise, required one");
        end
    endtask

    task automatic drain();
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while ((sb.size() != 0 || mon_active) && budget < 100);
        if (budget >= 100) begin
            checks++;
            errors++;
            $display("FAIL monitor_drain_timeout: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic apply(input logic which, input logic [11:0] val, input logic [3:0][6:0] dig,
                         input logic ovf_exp, input logic [7:0] id);
        exp_t e;
        if (which) d12 = val;
        else       d8  = val[7:0];
        wait_falls(which, 2);
        @(negedge clk);
        e.which = which;
        e.dig   = dig;
        e.ovf   = ovf_exp;
        e.id    = id;
        sb.push_back(e);
        drain();
    endtask

    // monitor: one full scan (4 digits x 4 cycles) per expected entry
    initial begin
        exp_t       e;
        logic [3:0] a, onehot;
        logic [6:0] s;
        logic       o;
        int         idx;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                mon_active = 1'b1;
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    a = e.which ? an12  : an8;
                    s = e.which ? seg12 : seg8;
                    o = e.which ? ovf12 : ovf8;
                    if (c == 0) begin
                        checks++;
                        if (o !== e.ovf) begin
                            errors++;
                            $display("FAIL ovf vec%0d: got %b, required %b", e.id, o, e.ovf);
                        end
                    end
                    idx = -1;
                    for (int i = 0; i < 4; i++) begin
                        onehot = 4'b0001 << i;
                        if (a == ~onehot) idx = i;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL anode vec%0d: got %b, required one-hot low", e.id, a);
                    end else if (s !== e.dig[idx]) begin
                        errors++;
                        $display("FAIL seg vec%0d digit%0d: got %b, required %b", e.id, idx, s, e.dig[idx]);
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_an;
        int         hits;
        int         lat;
        logic       seen_busy;
        logic       done;

        rst_n = 1'b0;
        d8    = 8'h00;
        d12   = 12'h000;
        repeat (3) @(negedge clk);
        check("reset seg", 32'(seg8), 'h7F);
        check("reset an", 32'(an8), 'hE);
        check("reset dp", 32'(dp8), 'h1);
        check("reset busy", 32'(busy8), 'h0);
        check("reset ovf", 32'(ovf8), 'h0);
        rst_n = 1'b1;

        for (int n = 1; n <= 32; n++) begin
            @(posedge clk);
            #1;
            exp_an = 4'b0001 << ((n / 4) % 4);
            exp_an = ~exp_an;
            check("scan order an", 32'(an8), 32'(exp_an));
        end

        apply(1'b0, 12'h000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 8'd1);
        apply(1'b0, 12'h0FD, {7'h3F, 7'h7F, 7'h7F, 7'h30}, 1'b0, 8'd2);
        apply(1'b0, 12'h080, {7'h3F, 7'h79, 7'h24, 7'h00}, 1'b0, 8'd3);
        apply(1'b0, 12'h07F, {7'h7F, 7'h79, 7'h24, 7'h78}, 1'b0, 8'd4);
        apply(1'b0, 12'h00A, {7'h7F, 7'h7F, 7'h79, 7'h40}, 1'b0, 8'd5);
        apply(1'b0, 12'h0FF, {7'h3F, 7'h7F, 7'h7F, 7'h79}, 1'b0, 8'd6);
        apply(1'b1, 12'h3E8, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 8'd7);
        apply(1'b1, 12'h3E7, {7'h7F, 7'h10, 7'h10, 7'h10}, 1'b0, 8'd8);
        apply(1'b1, 12'hC19, {7'h3F, 7'h10, 7'h10, 7'h10}, 1'b0, 8'd9);
        apply(1'b1, 12'hC18, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 8'd10);
        apply(1'b1, 12'h064, {7'h7F, 7'h79, 7'h40, 7'h40}, 1'b0, 8'd11);
        apply(1'b1, 12'h800, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 8'd12);

        // input change during a conversion must not disturb that conversion
        apply(1'b1, 12'd5, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0, 8'd13);
        wait_rise(1'b1);
        @(negedge clk);
        d12 = 12'd7;
        wait_falls(1'b1, 1);
        hits = 0;
        repeat (13) begin
            @(negedge clk);
            if (an12 == 4'b1110) begin
                hits++;
                check("hold5 digit0", 32'(seg12), 'h12);
            end
        end
        check("hold5 digit0 seen", 32'(hits > 0), 'h1);
        apply(1'b1, 12'd7, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0, 8'd14);

        // asynchronous reset in the middle of a shift, with ovf set beforehand
        apply(1'b1, 12'h3E8, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 8'd15);
        wait_rise(1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset seg", 32'(seg12), 'h7F);
        check("async reset an", 32'(an12), 'hE);
        check("async reset busy", 32'(busy12), 'h0);
        check("async reset ovf", 32'(ovf12), 'h0);
        check("async reset dp", 32'(dp12), 'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        seen_busy = 1'b0;
        done = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(posedge clk);
            #1;
            if (busy12) begin
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                lat  = n;
                done = 1'b1;
            end
        end
        check("restart commit latency", 32'(lat), 32'd14);
        check("restart commit ovf", 32'(ovf12), 'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
